// File: rtl/key_event_decoder.sv
// UART-byte to key-event decoder: maps received bytes onto configurable key codes,
// drives per-key hold levels with cooldown lockout, and queues key-index events.
module key_event_decoder #(
  parameter int unsigned NUM_KEYS                  = 6,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES       = {8'h0D, 8'h20, 8'h64, 8'h61, 8'h73, 8'h77},
  parameter int unsigned HOLD_CYCLES               = 1000,
  parameter int unsigned COOLDOWN_CYCLES           = 500000,
  parameter int unsigned CASE_FOLD                 = 1,
  parameter int unsigned FIFO_DEPTH                = 4,
  localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic                unknown_key,
  output logic                evt_valid,
  output logic [KW-1:0]       evt_key,
  input  logic                evt_ready,
  output logic [LW-1:0]       evt_level,
  output logic [7:0]          drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic                rx_valid_d;
  logic                acc;
  logic [7:0]          folded;
  logic                hit;
  logic [KW-1:0]       hit_idx;
  logic [NUM_KEYS-1:0] hit_sel;
  logic [NUM_KEYS-1:0] cd_idle;
  logic [NUM_KEYS-1:0] load;
  logic                push;
  logic                pop;
  logic                full;
  logic                push_ok;

  logic [15:0]         hold_cnt [NUM_KEYS];
  logic [19:0]         cooldown [NUM_KEYS];
  logic [KW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  always_comb begin
    folded = rx_data;
    if (CASE_FOLD != 0 && rx_data >= 8'h41 && rx_data <= 8'h5A) begin
      folded = rx_data | 8'h20;
    end
    hit     = 1'b0;
    hit_idx = '0;
    hit_sel = '0;
    cd_idle = '0;
    // Ascending scan with a found flag so the lowest index wins on duplicate codes.
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      cd_idle[i] = (cooldown[i] == '0);
      if (!hit && folded == KEY_CODES[8*i +: 8]) begin
        hit        = 1'b1;
        hit_idx    = KW'(i);
        hit_sel[i] = 1'b1;
      end
    end
    acc     = rx_valid & ~rx_valid_d;
    push    = acc & hit & (|(hit_sel & cd_idle));
    load    = push ? hit_sel : '0;
    full    = (level == LW'(FIFO_DEPTH));
    pop     = (level != '0) & evt_ready;
    push_ok = push & (~full | pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_d  <= 1'b1;
      unknown_key <= 1'b0;
    end else begin
      rx_valid_d  <= rx_valid;
      unknown_key <= acc & ~hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        hold_cnt[i] <= '0;
        cooldown[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (load[i]) begin
          hold_cnt[i] <= 16'(HOLD_CYCLES);
          cooldown[i] <= 20'(COOLDOWN_CYCLES);
        end else begin
          if (hold_cnt[i] != '0) hold_cnt[i] <= hold_cnt[i] - 16'd1;
          if (cooldown[i] != '0) cooldown[i] <= cooldown[i] - 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= hit_idx;
        wr_ptr           <= wr_ptr + AW'(1);
      end else if (push && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    key_hold = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      key_hold[i] = (hold_cnt[i] != '0);
    end
  end

  assign evt_valid = (level != '0);
  assign evt_key   = fifo_mem[rd_ptr];
  assign evt_level = level;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: two instances (case-folding, and non-folding with duplicate
// code and short cooldown) checked against a timestamp-based reference model and event scoreboards.
module tb_key_event_decoder;

  localparam int NK = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       evt_ready;

  logic [5:0] key_hold0, key_hold1;
  logic       unknown0, unknown1;
  logic       evt_valid0, evt_valid1;
  logic [2:0] evt_key0, evt_key1;
  logic [2:0] evt_level0, evt_level1;
  logic [7:0] drop0, drop1;

  always #5 clk = ~clk;

  key_event_decoder #(
    .NUM_KEYS(6),
    .KEY_CODES({8'h0D, 8'h20, 8'h64, 8'h61, 8'h73, 8'h77}),
    .HOLD_CYCLES(40),
    .COOLDOWN_CYCLES(60),
    .CASE_FOLD(1),
    .FIFO_DEPTH(4)
  ) u_fold (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_hold(key_hold0), .unknown_key(unknown0), .evt_valid(evt_valid0),
    .evt_key(evt_key0), .evt_ready(evt_ready), .evt_level(evt_level0),
    .drop_count(drop0)
  );

  key_event_decoder #(
    .NUM_KEYS(6),
    .KEY_CODES({8'h0D, 8'h61, 8'h64, 8'h61, 8'h73, 8'h77}),
    .HOLD_CYCLES(20),
    .COOLDOWN_CYCLES(8),
    .CASE_FOLD(0),
    .FIFO_DEPTH(4)
  ) u_nofold (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_hold(key_hold1), .unknown_key(unknown1), .evt_valid(evt_valid1),
    .evt_key(evt_key1), .evt_ready(evt_ready), .evt_level(evt_level1),
    .drop_count(drop1)
  );

  // Reference model: per-key "held until" and "free again at" cycle stamps.
  byte unsigned codes [2][NK] = '{'{8'h77, 8'h73, 8'h61, 8'h64, 8'h20, 8'h0D},
                                  '{8'h77, 8'h73, 8'h61, 8'h64, 8'h61, 8'h0D}};
  int     hold_p [2] = '{40, 20};
  int     cool_p [2] = '{60, 8};
  bit     fold_p [2] = '{1'b1, 1'b0};
  longint hold_until [2][NK];
  longint ready_at   [2][NK];
  int     lvl   [2];
  int     drops [2];
  bit     unk   [2];
  bit     prev_rv;
  longint cyc = 0;
  int     q0[$];
  int     q1[$];

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned pool [12] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h20, 8'h0D,
                              8'h57, 8'h53, 8'h41, 8'h44, 8'h5A, 8'h00};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    prev_rv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 0; drops[k] = 0; unk[k] = 1'b0;
      for (int j = 0; j < NK; j++) begin
        hold_until[k][j] = 0;
        ready_at[k][j]   = 0;
      end
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input bit rv, input byte unsigned rd, input bit rdy);
    bit acc;
    acc = rv && !prev_rv;
    prev_rv = rv;
    for (int k = 0; k < 2; k++) begin
      bit pop, took;
      byte unsigned b;
      int idx;
      pop  = (lvl[k] > 0) && rdy;
      took = 1'b0;
      unk[k] = 1'b0;
      if (acc) begin
        b = rd;
        if (fold_p[k] && b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
        idx = -1;
        for (int j = 0; j < NK; j++)
          if (idx < 0 && codes[k][j] == b) idx = j;
        if (idx < 0) begin
          unk[k] = 1'b1;
        end else if (cyc >= ready_at[k][idx]) begin
          hold_until[k][idx] = cyc + hold_p[k];
          ready_at[k][idx]   = cyc + cool_p[k] + 1;
          took = 1'b1;
          if (lvl[k] < 4 || pop) begin
            if (k == 0) q0.push_back(idx); else q1.push_back(idx);
            lvl[k]++;
          end else if (drops[k] < 255) begin
            drops[k]++;
          end
        end
      end
      if (pop) lvl[k]--;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int eh;
      eh = 0;
      for (int j = 0; j < NK; j++)
        if (cyc < hold_until[k][j]) eh = eh | (1 << j);
      chk(k == 0 ? "key_hold0" : "key_hold1", int'(k == 0 ? key_hold0 : key_hold1), eh);
      chk(k == 0 ? "unknown0" : "unknown1", int'(k == 0 ? unknown0 : unknown1), int'(unk[k]));
      chk(k == 0 ? "evt_valid0" : "evt_valid1", int'(k == 0 ? evt_valid0 : evt_valid1), int'(lvl[k] != 0));
      chk(k == 0 ? "evt_level0" : "evt_level1", int'(k == 0 ? evt_level0 : evt_level1), lvl[k]);
      chk(k == 0 ? "drop0" : "drop1", int'(k == 0 ? drop0 : drop1), drops[k]);
    end
  endtask

  task automatic check_cleared();
    chk("rst_key_hold0", int'(key_hold0), 0);
    chk("rst_unknown0", int'(unknown0), 0);
    chk("rst_evt_valid0", int'(evt_valid0), 0);
    chk("rst_evt_key0", int'(evt_key0), 0);
    chk("rst_evt_level0", int'(evt_level0), 0);
    chk("rst_drop0", int'(drop0), 0);
    chk("rst_key_hold1", int'(key_hold1), 0);
    chk("rst_evt_valid1", int'(evt_valid1), 0);
    chk("rst_evt_level1", int'(evt_level1), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step(rx_valid, rx_data, evt_ready);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input byte unsigned b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_cleared();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitors: a handshake at the coming edge consumes the head event.
  always @(negedge clk) begin
    if (!reset && evt_valid0 && evt_ready) begin
      int e;
      if (q0.size() != 0) e = q0.pop_front(); else e = -1;
      chk("evt_key0", int'(evt_key0), e);
    end
  end

  always @(negedge clk) begin
    if (!reset && evt_valid1 && evt_ready) begin
      int e;
      if (q1.size() != 0) e = q1.pop_front(); else e = -1;
      chk("evt_key1", int'(evt_key1), e);
    end
  end

  initial begin
    rx_valid  = 1'b1;
    rx_data   = 8'h77;
    evt_ready = 1'b0;
    reset     = 1'b0;
    #1;
    do_reset();
    idle(5);
    rx_valid = 1'b0;
    tick();
    press(8'h77);
    idle(45);

    idle(20);
    press(8'h57);
    evt_ready = 1'b1;
    idle(4);
    evt_ready = 1'b0;

    press(8'h73);
    idle(98);
    press(8'h73);
    idle(10);

    press(8'h61);
    idle(57);
    press(8'h61);
    press(8'h61);
    evt_ready = 1'b1;
    idle(6);
    evt_ready = 1'b0;

    idle(70);
    press(8'h77);
    press(8'h73);
    press(8'h61);
    press(8'h64);
    press(8'h20);
    idle(3);
    rx_data   = 8'h0D;
    rx_valid  = 1'b1;
    evt_ready = 1'b1;
    tick();
    rx_valid  = 1'b0;
    evt_ready = 1'b0;
    tick();
    evt_ready = 1'b1;
    idle(6);
    evt_ready = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) rx_data = 8'($urandom);
      else rx_data = pool[$urandom_range(0, 11)];
      evt_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    rx_valid  = 1'b0;
    evt_ready = 1'b0;
    idle(70);
    press(8'h77);
    press(8'h73);
    idle(10);
    do_reset();
    tick();
    press(8'h77);
    idle(5);

    evt_ready = 1'b1;
    idle(50);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
